game_state_controller: RTL
==========================

// Module: game_state_controller
// PURPOSE
//  Top-level game FSM that drives logic_handler's enable inputs: startGameEn, shipUpdateEn
//  and gridUpdateEn. Holds the game in IDLE, runs an INIT pulse that clears all datapath
//  state, times the movement and grid-shift ticks during RUN, supports PAUSE, and detects
//  game over from ship_health.
// PARAMETERS
//  SHIP_PERIOD   833333   clk cycles between shipUpdateEn pulses (60 Hz at 50 MHz); >=2
//  GRID_PERIOD   1666666  clk cycles between gridUpdateEn pulses (30 Hz at 50 MHz); >=2
//  INIT_CYCLES   4        cycles startGameEn is held high in INIT; >=1
// PORTS
//  clk              in   1  50 MHz system clock
//  reset            in   1  asynchronous, active-high reset
//  start            in   1  start/restart request, level, already debounced, active-high
//  pause            in   1  pause toggle request, level, already debounced, active-high
//  ship_health      in   4  current ship health from health_handler
//  startGameEn      out  1  high throughout INIT; clears logic_handler submodules
//  shipUpdateEn     out  1  one-cycle tick: ship/enemy movement update
//  gridUpdateEn     out  1  one-cycle tick: bullet grid shift
//  gameover_signal  out  1  one-cycle pulse on entry to OVER (best-score latch)
//  game_over        out  1  level, high while in OVER
//  state            out  3  encoded state: IDLE=0, INIT=1, RUN=2, PAUSE=3, OVER=4
// BEHAVIOUR
//  - Reset (async, any cycle): state=IDLE; all outputs 0; divider counters 0; edge regs 0.
//  - start and pause are rising-edge detected against a registered copy.
//    Holding an input high gives exactly one event.
//  - IDLE: start edge -> INIT. Nothing else is honoured.
//  - INIT: startGameEn=1 for exactly INIT_CYCLES cycles, then -> RUN.
//    ship_health is ignored in INIT. Both dividers are cleared to 0.
//  - RUN: ship_cnt counts 0..SHIP_PERIOD-1 and wraps; grid_cnt counts 0..GRID_PERIOD-1 and wraps.
//    Each counter is $clog2(PERIOD) bits wide.
//    - shipUpdateEn is registered, high for one cycle when ship_cnt wraps. The first pulse
//      is on the SHIP_PERIOD-th cycle after entering RUN. gridUpdateEn behaves the same way.
//    - Both ticks may fire in the same cycle; this is legal.
//  - RUN: ship_health==0 -> OVER. This has priority over pause and over tick generation;
//    no tick is issued in the transition cycle.
//  - RUN: pause edge (and health!=0) -> PAUSE. Counters freeze, ticks are forced to 0.
//  - PAUSE: pause edge -> RUN. Counters resume from their frozen values, so total RUN
//    cycles between ticks stays exactly PERIOD. start edge in PAUSE is ignored.
//  - OVER: gameover_signal=1 on the first OVER cycle only; game_over=1 throughout.
//    Ticks are 0. A start edge -> INIT (restart); game_over drops on leaving OVER.
//  - A start edge and a pause edge in the same cycle: only the edge legal in the current
//    state is taken.
//  - Any undefined state encoding recovers to IDLE on the next clock.
//  - Outputs are all registered; there are no combinational paths from inputs to outputs.
// TESTING (bench params: SHIP_PERIOD=4, GRID_PERIOD=6, INIT_CYCLES=2)
//  1. Reset, start pulse -> state 0->1. startGameEn high 2 cycles. state=2.
//     First shipUpdateEn 4 cycles into RUN, first gridUpdateEn 6 cycles into RUN.
//  2. Hold start high for 20 cycles from IDLE -> exactly one INIT. No re-entry while held.
//  3. RUN 2 cycles, pause edge, wait 10 cycles, pause edge -> zero ticks while paused.
//     Next shipUpdateEn comes 2 RUN cycles after resume.
//  4. ship_health=0 on the cycle a tick is due -> state=4, no tick issued.
//     gameover_signal high exactly 1 cycle; game_over stays 1.
//  5. In OVER, start edge -> INIT with startGameEn 2 cycles and game_over=0, then RUN.
//     ship_health=0 during INIT does not trigger OVER.
//  6. Assert reset mid-RUN asynchronously (between edges) -> all outputs 0 and state=0
//     immediately. After release, no activity until a start edge.

Source files
------------

// File: rtl/game_state_controller.sv
// game_state_controller: game FSM producing init, movement and grid-shift enables from start/pause/health.
module game_state_controller #(
  parameter int SHIP_PERIOD = 833333,
  parameter int GRID_PERIOD = 1666666,
  parameter int INIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] ship_health,
  output logic       startGameEn,
  output logic       shipUpdateEn,
  output logic       gridUpdateEn,
  output logic       gameover_signal,
  output logic       game_over,
  output logic [2:0] state
);
  localparam int SW = $clog2(SHIP_PERIOD);
  localparam int GW = $clog2(GRID_PERIOD);
  localparam int IW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
  localparam logic [SW-1:0] SHIP_MAX = SW'(SHIP_PERIOD - 1);
  localparam logic [GW-1:0] GRID_MAX = GW'(GRID_PERIOD - 1);
  localparam logic [IW-1:0] INIT_MAX = IW'(INIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, INIT = 3'd1, RUN = 3'd2, PAUSE = 3'd3, OVER = 3'd4} state_t;
  state_t        state_q;
  logic          start_q, pause_q;
  logic [SW-1:0] ship_cnt_q;
  logic [GW-1:0] grid_cnt_q;
  logic [IW-1:0] init_cnt_q;
  logic          start_en_q, ship_tick_q, grid_tick_q, go_pulse_q, go_level_q;
  logic          start_ev, pause_ev;
  assign start_ev        = start & ~start_q;
  assign pause_ev        = pause & ~pause_q;
  assign state           = state_q;
  assign startGameEn     = start_en_q;
  assign shipUpdateEn    = ship_tick_q;
  assign gridUpdateEn    = grid_tick_q;
  assign gameover_signal = go_pulse_q;
  assign game_over       = go_level_q;
  // Ticks and the game-over pulse default low each cycle; only RUN wraps raise ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      ship_cnt_q  <= '0;
      grid_cnt_q  <= '0;
      init_cnt_q  <= '0;
      start_en_q  <= 1'b0;
      ship_tick_q <= 1'b0;
      grid_tick_q <= 1'b0;
      go_pulse_q  <= 1'b0;
      go_level_q  <= 1'b0;
    end else begin
      start_q     <= start;
      pause_q     <= pause;
      ship_tick_q <= 1'b0;
      grid_tick_q <= 1'b0;
      go_pulse_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_ev) begin
          state_q    <= INIT;
          start_en_q <= 1'b1;
          init_cnt_q <= '0;
        end
        INIT: begin
          ship_cnt_q <= '0;
          grid_cnt_q <= '0;
          if (init_cnt_q == INIT_MAX) begin
            state_q    <= RUN;
            start_en_q <= 1'b0;
          end else init_cnt_q <= init_cnt_q + 1'b1;
        end
        RUN: if (ship_health == 4'd0) begin
          state_q    <= OVER;
          go_pulse_q <= 1'b1;
          go_level_q <= 1'b1;
        end else if (pause_ev) state_q <= PAUSE;
        else begin
          ship_cnt_q  <= ship_cnt_q == SHIP_MAX ? '0 : ship_cnt_q + 1'b1;
          grid_cnt_q  <= grid_cnt_q == GRID_MAX ? '0 : grid_cnt_q + 1'b1;
          ship_tick_q <= ship_cnt_q == SHIP_MAX;
          grid_tick_q <= grid_cnt_q == GRID_MAX;
        end
        PAUSE: if (pause_ev) state_q <= RUN;
        OVER: if (start_ev) begin
          state_q    <= INIT;
          go_level_q <= 1'b0;
          start_en_q <= 1'b1;
          init_cnt_q <= '0;
        end
        default: begin
          state_q    <= IDLE;
          start_en_q <= 1'b0;
          go_level_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
